// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer and its lock filter.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        SW_HOLD = 2'd3
    } reset_seq_state_t;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lock_filter.sv
// Qualifies a raw PLL lock flag: lock_ok rises only after LOCK_FILTER
// consecutive locked cycles and drops on the first unlocked cycle.
module lock_filter
    import reset_seq_pkg::*;
#(
    parameter int LOCK_FILTER = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pll_locked,
    output logic lock_ok
);

    localparam int            CW      = cnt_width(LOCK_FILTER);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_FILTER);

    logic [CW-1:0] lock_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt <= '0;
            lock_ok  <= 1'b0;
        end else if (!pll_locked) begin
            lock_cnt <= '0;
            lock_ok  <= 1'b0;
        end else begin
            if (lock_cnt != CNT_MAX) lock_cnt <= lock_cnt + 1'b1;
            // lock_ok tracks the count as it lands on CNT_MAX, not one edge later.
            lock_ok <= (lock_cnt >= CNT_MAX - 1'b1);
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES downstream resets in order once board reset and PLL
// lock are stable; supports a software reset via a req/ack handshake.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int LOCK_FILTER = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ext_resetn,
    input  logic                  pll_locked,
    input  logic                  sw_rst_req,
    output logic                  sw_rst_ack,
    output logic [NUM_STAGES-1:0] stage_resetn,
    output logic                  all_released,
    output logic                  lock_lost,
    output reset_seq_state_t      state_dbg
);

    // Handshake: sw_rst_req is a level sampled only in RUN; sw_rst_ack is a
    // single-cycle pulse after the hold, and the requester must drop req on it.

    localparam int             HCW       = cnt_width(HOLD_CYCLES);
    localparam int             GCW       = cnt_width(STAGE_GAP);
    localparam int             SIW       = cnt_width(NUM_STAGES);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'(STAGE_GAP - 1);
    localparam logic [SIW-1:0] LAST_IDX  = SIW'(NUM_STAGES - 1);

    reset_seq_state_t      state, state_n;
    logic [HCW-1:0]        hold_cnt, hold_n;
    logic [GCW-1:0]        gap_cnt, gap_n;
    logic [SIW-1:0]        stage_idx, idx_n;
    logic [NUM_STAGES-1:0] stage_n;
    logic                  all_n, ack_n, lost_n;
    logic                  lock_ok, good;

    lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_lock_filter (
        .clk        (clk),
        .reset      (reset),
        .pll_locked (pll_locked),
        .lock_ok    (lock_ok)
    );

    assign good      = ext_resetn & lock_ok;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= HOLD;
            hold_cnt     <= '0;
            gap_cnt      <= '0;
            stage_idx    <= '0;
            stage_resetn <= '0;
            all_released <= 1'b0;
            sw_rst_ack   <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            state        <= state_n;
            hold_cnt     <= hold_n;
            gap_cnt      <= gap_n;
            stage_idx    <= idx_n;
            stage_resetn <= stage_n;
            all_released <= all_n;
            sw_rst_ack   <= ack_n;
            lock_lost    <= lost_n;
        end
    end

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        gap_n   = gap_cnt;
        idx_n   = stage_idx;
        stage_n = stage_resetn;
        all_n   = all_released;
        ack_n   = 1'b0;
        lost_n  = lock_lost | ((state == RUN) && !lock_ok);

        if (state != HOLD && !good) begin
            // Abort beats software requests and pending stage releases.
            state_n = HOLD;
            stage_n = '0;
            all_n   = 1'b0;
            hold_n  = '0;
            gap_n   = '0;
            idx_n   = '0;
        end else begin
            case (state)
                HOLD: begin
                    stage_n = '0;
                    all_n   = 1'b0;
                    gap_n   = '0;
                    idx_n   = '0;
                    if (!good) begin
                        hold_n = '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        hold_n = '0;
                        if (NUM_STAGES == 1) begin
                            state_n = RUN;
                            stage_n = '1;
                            all_n   = 1'b1;
                        end else begin
                            state_n = RELEASE;
                            stage_n = NUM_STAGES'(1);
                            idx_n   = SIW'(1);
                        end
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_n = '0;
                        idx_n = stage_idx + 1'b1;
                        for (int k = 0; k < NUM_STAGES; k++) begin
                            if (SIW'(k) == stage_idx) stage_n[k] = 1'b1;
                        end
                        if (stage_idx == LAST_IDX) begin
                            state_n = RUN;
                            all_n   = 1'b1;
                            idx_n   = '0;
                        end
                    end else begin
                        gap_n = gap_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (sw_rst_req) begin
                        state_n = SW_HOLD;
                        stage_n = '0;
                        all_n   = 1'b0;
                        hold_n  = '0;
                    end
                end
                SW_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = HOLD;
                        ack_n   = 1'b1;
                        hold_n  = '0;
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end
                default: state_n = HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: per-cycle expected outputs go through a
// scoreboard queue and are checked one cycle later against the DUT.
module tb_reset_sequencer;
    import reset_seq_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             ext_resetn;
    logic             pll_locked;
    logic             sw_rst_req;
    logic             sw_rst_ack;
    logic [3:0]       stage_resetn;
    logic             all_released;
    logic             lock_lost;
    reset_seq_state_t state_dbg;

    logic [6:0] exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    string      cur_tag     = "init";

    // Expected vector layout: {sw_rst_ack, lock_lost, all_released, stage_resetn}
    localparam logic [6:0] V0   = 7'b000_0000;
    localparam logic [6:0] VS1  = 7'b000_0001;
    localparam logic [6:0] VS2  = 7'b000_0011;
    localparam logic [6:0] VS3  = 7'b000_0111;
    localparam logic [6:0] VALL = 7'b001_1111;
    localparam logic [6:0] LL   = 7'b010_0000;
    localparam logic [6:0] ACK  = 7'b100_0000;

    reset_sequencer #(
        .NUM_STAGES(4), .HOLD_CYCLES(16), .STAGE_GAP(8), .LOCK_FILTER(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ext_resetn   (ext_resetn),
        .pll_locked   (pll_locked),
        .sw_rst_req   (sw_rst_req),
        .sw_rst_ack   (sw_rst_ack),
        .stage_resetn (stage_resetn),
        .all_released (all_released),
        .lock_lost    (lock_lost),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [6:0] exp);
        logic [6:0] got;
        logic [6:0] want;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got  = {sw_rst_ack, lock_lost, all_released, stage_resetn};
        want = exp_q.pop_front();
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s t=%0t got=%b exp=%b", cur_tag, $time, got, want);
        end
    endtask

    task automatic run(input int n, input logic [6:0] exp);
        for (int i = 0; i < n; i++) step(exp);
    endtask

    // Full release from the edge after stage 0 (stage 0 edge included).
    task automatic release_seq(input logic [6:0] base);
        run(8, base | VS1);
        run(8, base | VS2);
        run(8, base | VS3);
        run(2, base | VALL);
    endtask

    initial begin
        reset      = 1'b1;
        ext_resetn = 1'b1;
        pll_locked = 1'b1;
        sw_rst_req = 1'b0;

        cur_tag = "reset";
        run(3, V0);
        vectors++;
        assert (state_dbg === HOLD) else begin
            miscompares++;
            $error("FAIL reset_state got=%0d exp=%0d", state_dbg, HOLD);
        end

        cur_tag = "power_up";
        reset = 1'b0;
        run(19, V0);
        release_seq(V0);

        cur_tag = "lock_drop";
        pll_locked = 1'b0;
        step(VALL);
        pll_locked = 1'b1;
        step(LL);
        run(18, LL);
        release_seq(LL);

        cur_tag = "sw_reset";
        sw_rst_req = 1'b1;
        step(LL);
        run(15, LL);
        step(LL | ACK);
        sw_rst_req = 1'b0;
        run(15, LL);
        run(8, LL | VS1);
        run(3, LL | VS2);

        cur_tag = "ext_glitch_release";
        ext_resetn = 1'b0;
        step(LL);
        ext_resetn = 1'b1;
        run(15, LL);
        release_seq(LL);

        cur_tag = "ext_toggle_hold";
        ext_resetn = 1'b0;
        step(LL);
        for (int i = 0; i < 4; i++) begin
            ext_resetn = 1'b1;
            run(10, LL);
            ext_resetn = 1'b0;
            run(10, LL);
        end
        cur_tag = "after_toggle";
        ext_resetn = 1'b1;
        run(15, LL);
        release_seq(LL);

        cur_tag = "sw_abort";
        sw_rst_req = 1'b1;
        step(LL);
        run(5, LL);
        pll_locked = 1'b0;
        step(LL);
        pll_locked = 1'b1;
        step(LL);
        run(18, LL);
        run(8, LL | VS1);
        run(8, LL | VS2);
        run(8, LL | VS3);
        step(LL | VALL);
        cur_tag = "sw_retrigger";
        step(LL);
        run(15, LL);
        step(LL | ACK);
        sw_rst_req = 1'b0;
        run(15, LL);
        step(LL | VS1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
